// File: rtl/noise_sequencer.sv
// noise_sequencer: free-running sample/tick dividers plus a 16-step trigger pattern player
module noise_sequencer #(
  parameter int SAMPLE_DIV = 1024,
  parameter int TICK_DIV   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] speed,
  input  logic       pat_we,
  input  logic [3:0] pat_addr,
  input  logic       pat_din,
  output logic       sample_clk,
  output logic       tick_clk,
  output logic       song_clk,
  output logic       note_trigger,
  output logic [3:0] step_idx,
  output logic       playing
);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PLAY} state_t;
  state_t r_state, w_state;
  logic [SW-1:0] r_scnt;
  logic [TW-1:0] r_tcnt;
  logic [15:0] r_pat;
  logic [3:0] r_sub, r_spd, r_step, w_sub, w_spd, w_step;
  logic r_sample, r_tick, r_song, r_note, r_play, w_song, w_tick;
  // strobes are registered, so the FSM acts on the cycle before tick_clk rises
  assign w_tick = r_sample && r_tcnt == TW'(TICK_DIV - 1);
  always_comb begin
    w_state = r_state;
    w_step  = r_step;
    w_sub   = r_sub;
    w_spd   = r_spd;
    w_song  = 1'b0;
    case (r_state)
      S_IDLE: w_state = start && !stop ? S_ARM : S_IDLE;
      S_ARM:
        if (stop) w_state = S_IDLE;
        else if (w_tick) begin
          w_state = S_PLAY;
          w_step  = 4'd0;
          w_sub   = 4'd0;
          w_spd   = speed;
          w_song  = 1'b1;
        end
      S_PLAY:
        if (stop) begin
          w_state = S_IDLE;
          w_step  = 4'd0;
          w_sub   = 4'd0;
        end else if (w_tick) begin
          w_song = r_sub == r_spd;
          w_sub  = w_song ? 4'd0 : r_sub + 4'd1;
          w_step = w_song ? r_step + 4'd1 : r_step;
          w_spd  = w_song ? speed : r_spd;
        end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_scnt   <= '0;
      r_tcnt   <= '0;
      r_pat    <= '0;
      r_sub    <= '0;
      r_spd    <= '0;
      r_step   <= '0;
      r_sample <= 1'b0;
      r_tick   <= 1'b0;
      r_song   <= 1'b0;
      r_note   <= 1'b0;
      r_play   <= 1'b0;
    end else begin
      r_scnt   <= r_scnt == SW'(SAMPLE_DIV - 1) ? '0 : r_scnt + 1'b1;
      r_sample <= r_scnt == SW'(SAMPLE_DIV - 2);
      if (r_sample) r_tcnt <= r_tcnt == TW'(TICK_DIV - 1) ? '0 : r_tcnt + 1'b1;
      r_tick   <= w_tick;
      r_state  <= w_state;
      r_sub    <= w_sub;
      r_spd    <= w_spd;
      r_step   <= w_step;
      r_song   <= w_song;
      // read before this cycle's write lands, so a colliding write emits the old bit
      r_note   <= w_song & r_pat[w_step];
      r_play   <= w_state == S_PLAY;
      if (pat_we) r_pat[pat_addr] <= pat_din;
    end
  end
  assign sample_clk   = r_sample;
  assign tick_clk     = r_tick;
  assign song_clk     = r_song;
  assign note_trigger = r_note;
  assign step_idx     = r_step;
  assign playing      = r_play;
endmodule

// File: tb/tb_noise_sequencer.sv
// tb_noise_sequencer: scoreboard bench against a cycle-index based reference model
module tb_noise_sequencer;
  logic clk = 0, rst = 1, start = 0, stop = 0, pat_we = 0, pat_din = 0;
  logic [3:0] speed = 0, pat_addr = 0;
  logic sample_clk, tick_clk, song_clk, note_trigger, playing;
  logic [3:0] step_idx;
  int checks = 0, errors = 0;
  noise_sequencer #(.SAMPLE_DIV(4), .TICK_DIV(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .speed(speed),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din),
    .sample_clk(sample_clk), .tick_clk(tick_clk), .song_clk(song_clk),
    .note_trigger(note_trigger), .step_idx(step_idx), .playing(playing)
  );
  always #5 clk = ~clk;
  typedef struct {int step; bit note;} ev_t;
  ev_t q[$];
  int m_n = 0, m_mode = 0, m_step = 0, m_left = 0;
  bit m_pat[16];
  bit m_ok = 0;
  bit e_sample, e_tick, e_song, e_play;
  int e_step;
  // model: m_n is the index of the cycle about to begin; tick every 12th cycle
  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_mode = 0; m_step = 0; m_left = 0; e_song = 0; m_ok = 1;
      foreach (m_pat[i]) m_pat[i] = 0;
      q.delete();
    end else begin
      m_n++;
      e_song = 0;
      if (stop) begin m_mode = 0; m_step = 0; end
      else if (m_mode == 0) begin if (start) m_mode = 1; end
      else if (m_n % 12 == 0) begin
        if (m_mode == 1) begin m_mode = 2; m_step = 0; m_left = speed; e_song = 1; end
        else if (m_left == 0) begin m_step = (m_step + 1) % 16; m_left = speed; e_song = 1; end
        else m_left--;
      end
      if (e_song) q.push_back('{m_step, m_pat[m_step]});
      if (pat_we) m_pat[pat_addr] = pat_din;
    end
    e_sample = m_n % 4 == 3;
    e_tick   = m_n > 0 && m_n % 12 == 0;
    e_play   = m_mode == 2;
    e_step   = m_step;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, m_n, act, exp);
    end
  endtask
  always @(negedge clk) if (m_ok) begin
    ev_t ev;
    chk("sample_clk", 32'(sample_clk), 32'(e_sample));
    chk("tick_clk", 32'(tick_clk), 32'(e_tick));
    chk("song_clk", 32'(song_clk), 32'(e_song));
    chk("playing", 32'(playing), 32'(e_play));
    chk("step_idx", 32'(step_idx), 32'(e_step));
    if (song_clk === 1'b1) begin
      if (q.size() == 0) chk("song_unexpected", 32'(song_clk), 32'd0);
      else begin
        ev = q.pop_front();
        chk("song_step", 32'(step_idx), 32'(ev.step));
        chk("song_note", 32'(note_trigger), 32'(ev.note));
      end
    end else chk("note_idle", 32'(note_trigger), 32'd0);
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic do_rst();
    rst = 1; cyc(1); rst = 0;
  endtask
  task automatic pulse_start(input logic [3:0] spd);
    speed = spd; start = 1; cyc(1); start = 0;
  endtask
  task automatic wait_play();
    for (int i = 0; i < 100 && playing !== 1'b1; i++) cyc(1);
    chk("play_timeout", 32'(playing), 32'd1);
  endtask
  initial begin
    bit done;
    cyc(3); rst = 0;
    cyc(40);
    do_rst();
    pat_we = 1; pat_addr = 0; pat_din = 1; cyc(1);
    pat_addr = 2; cyc(1);
    pat_we = 0; pulse_start(4'd1);
    cyc(70);
    do_rst();
    for (int i = 0; i < 16; i++) begin
      pat_we = 1; pat_addr = 4'(i); pat_din = 1'($urandom); cyc(1);
    end
    pat_we = 0; pulse_start(4'd0);
    cyc(12 * 18 + 12);
    start = 1; stop = 1; cyc(1); start = 0; stop = 0;
    cyc(30);
    do_rst();
    pulse_start(4'd0);
    wait_play();
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (m_mode == 2 && m_step == 0 && (m_n + 1) % 12 == 0) begin
        pat_we = 1; pat_addr = 4'd1; pat_din = 1; done = 1;
      end
      cyc(1);
      pat_we = 0;
    end
    chk("collide_timeout", 32'(done), 32'd1);
    cyc(16 * 12 + 24);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(39) == 0;
      stop = $urandom_range(199) == 0;
      pat_we = $urandom_range(3) == 0;
      pat_addr = 4'($urandom);
      pat_din = 1'($urandom);
      if ($urandom_range(29) == 0) speed = 4'($urandom_range(2));
      cyc(1);
    end
    start = 0; stop = 0; pat_we = 0;
    pulse_start(4'd0);
    wait_play();
    cyc(20);
    do_rst();
    cyc(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
